// File: rtl/alu_op_sequencer.sv
// Issue-and-writeback stage in front of an 8-bit combinational ALU: reads a
// 4 x 8-bit register file, drives registered ALU inputs, captures result/flags.
module alu_op_sequencer #(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [1:0] instr_dst,
  input  logic [1:0] instr_srca,
  input  logic [1:0] instr_srcb,
  input  logic       instr_use_imm,
  input  logic [7:0] instr_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic       res_err,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high. instr_ready is high only in IDLE; res_valid is high only in DONE,
  // and res_* hold steady from DONE entry until the edge that sees res_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0011;

  state_t     r_state;
  state_t     w_next_state;

  logic [7:0] r_regs [NREGS];
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [3:0] r_alu_op;
  logic [1:0] r_dst;
  logic [7:0] r_res_data;
  logic       r_res_carry;
  logic       r_res_zero;
  logic       r_res_err;

  logic       w_accept;
  logic       w_capture;
  logic [7:0] w_rd_a;
  logic [7:0] w_rd_b;
  logic       w_div_zero;
  logic [7:0] w_cap_data;
  logic       w_cap_carry;
  logic       w_cap_zero;

  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    res_valid    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_accept  = (r_state == S_IDLE) && instr_valid;
  assign w_capture = (r_state == S_EXEC);

  // Operand reads see pre-write values; writeback always lands before IDLE.
  assign w_rd_a = r_regs[instr_srca];
  assign w_rd_b = instr_use_imm ? instr_imm : r_regs[instr_srcb];

  // Divide by zero overrides whatever the ALU produced.
  assign w_div_zero  = (r_alu_op == OP_DIV) && (r_alu_b == 8'h00);
  assign w_cap_data  = w_div_zero ? 8'hFF : alu_result;
  assign w_cap_carry = (r_alu_op == OP_ADD) && alu_carry;
  assign w_cap_zero  = !w_div_zero && (alu_result == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_op    <= 4'h0;
      r_dst       <= 2'd0;
      r_res_data  <= 8'h00;
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_err   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_alu_a  <= w_rd_a;
        r_alu_b  <= w_rd_b;
        r_alu_op <= instr_op;
        r_dst    <= instr_dst;
      end
      if (w_capture) begin
        r_res_data  <= w_cap_data;
        r_res_carry <= w_cap_carry;
        r_res_zero  <= w_cap_zero;
        r_res_err   <= w_div_zero;
        if (!w_div_zero) begin
          r_regs[r_dst] <= alu_result;
        end
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_zero  = r_res_zero;
  assign res_err   = r_res_err;
  assign dbg_state = r_state;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue-and-writeback stage that sits directly upstream of the 8-bit ALU. It accepts one instruction per valid/ready handshake and reads operands from a 4-entry × 8-bit register file (or an immediate). It drives the ALU's operand and operation inputs from registers, captures the combinational ALU result and carry, and writes the result back. Each completed operation, with status flags, is presented on a downstream valid/ready result port.

## Interface
- `NREGS`, 4: register-file depth; fixed at 4, index width 2.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `instr_valid` input 1: instruction present.
- `instr_ready` output 1: stage can accept an instruction; high only in IDLE.
- `instr_op` input 4: ALU operation code; same encoding as the ALU `operation` port.
- `instr_dst` input 2: destination register index.
- `instr_srca` input 2: source register for operand A.
- `instr_srcb` input 2: source register for operand B.
- `instr_use_imm` input 1: 1 selects `instr_imm` as operand B.
- `instr_imm` input 8: immediate operand B.
- `alu_a` output 8: registered operand A, drives ALU `operand_a`.
- `alu_b` output 8: registered operand B, drives ALU `operand_b`.
- `alu_op` output 4: registered opcode, drives ALU `operation`.
- `alu_result` input 8: ALU `result`.
- `alu_carry` input 1: ALU `carry_out`, which is the add carry regardless of opcode.
- `res_valid` output 1: result available.
- `res_ready` input 1: downstream accepts the result.
- `res_data` output 8: result value.
- `res_carry` output 1: carry flag.
- `res_zero` output 1: zero flag.
- `res_err` output 1: divide-by-zero error.

## Operation
- FSM has three states: IDLE, EXEC and DONE.
  - IDLE: `instr_ready`=1. When `instr_valid` is high, the stage latches the following and moves to EXEC:
    - `alu_a` = regfile[srca].
    - `alu_b` = use_imm ? imm : regfile[srcb].
    - `alu_op` = op.
    - dst.
  - EXEC: ALU inputs are stable all cycle. At the end of the cycle the stage performs the capture below and moves to DONE.
    - `res_data` ← `alu_result`.
    - `res_carry` ← (`alu_op`==4'b0000) ? `alu_carry` : 0.
    - `res_zero` ← (`alu_result`==0).
    - `res_err` ← (`alu_op`==4'b0011 && `alu_b`==0).
    - If `res_err`=0, then regfile[dst] ← `alu_result` on the same edge.
  - DONE: `res_valid`=1 and all `res_*` outputs are held stable. When `res_ready`=1, the FSM goes to IDLE on the next edge.
- Divide-by-zero (op 0011, B=0) is defined as follows; the ALU output is ignored in this case:
  - `res_data` is forced to 8'hFF.
  - `res_zero`=0 and `res_err`=1.
  - The register file is unchanged.
- Opcode-specific behaviour:
  - Results of multiply (0010) are the low 8 bits as supplied by the ALU; there is no overflow flag.
  - Compare ops (1110, 1111) write 0 or 1 to dst like any other op.
  - Unary ops (0100–0111) ignore B, but B is still latched.
- Read-after-write: writeback completes before IDLE is re-entered, so the next instruction always reads the updated value. No bypass is needed.
- `srca`, `srcb` and `dst` may all be equal; reads use pre-write values of the current instruction.
- `instr_*` inputs are ignored outside IDLE.
- `alu_a`, `alu_b` and `alu_op` change only on the IDLE→EXEC edge.

## Timing
- Handshake cycle N: `instr_valid` & `instr_ready` in IDLE.
- Cycle N+1: EXEC; `alu_a`, `alu_b` and `alu_op` carry the new values.
- Cycle N+2: DONE; `res_valid`=1 and regfile[dst] is visible.
- Minimum issue interval is 3 cycles (N, then next accept at N+3 if `res_ready` is high at N+2).
- `res_ready` low stalls in DONE indefinitely; `instr_ready` stays 0.
- Reset, checked at every edge and overriding all else:
  - state=IDLE.
  - regfile all 0.
  - `alu_a`, `alu_b`, `alu_op` = 0.
  - `res_valid`, `res_data`, `res_carry`, `res_zero`, `res_err` = 0.
  - `instr_ready` reads 1 in the first cycle after reset.
- Reset asserted in EXEC suppresses the writeback; reset in DONE drops the pending result.

## Test plan
- Reset, then ADD with imm: r1 ← r0 + imm 8'h05, then r2 ← r1 + imm 8'hFB.
  - Required: first result 8'h05, carry 0, zero 0.
  - Required: second result 8'h00, carry 1, zero 1, with `res_valid` exactly 2 cycles after accept.
- RAW chain of back-to-back instructions, `res_ready` tied 1:
  - Load r3=8'h0F by ADD imm.
  - Then r3 ← r3 ROL (0110) → 8'h1E.
  - Then r3 ← r3 AND imm 8'h16 → 8'h16.
  - Required: accepts every 3 cycles.
- Divide: r1=8'h64, DIV by imm 8'h07.
  - Required: 8'h0E, err 0.
  - Then DIV by imm 8'h00 into r1.
  - Required: `res_data` 8'hFF, err 1, zero 0, r1 still 8'h0E (verify by ADD r1 + imm 0).
- Backpressure: hold `res_ready`=0 for 10 cycles in DONE while `instr_valid` is high with a different instruction.
  - Required: `res_*` stable, `instr_ready`=0, `alu_*` unchanged, and the second instruction is accepted only after the result handshake.
- Compare ops: r0=8'h80, r1=8'h7F.
  - GT (1110) r0,r1 → 1.
  - GT r1,r0 → 0 with zero=1.
  - EQ (1111) r0,r0 → 1.
  - SUB r1−r0 → 8'hFF with carry 0.
- Reset in EXEC of a write to r2 (previously 8'h33).
  - Required: next cycle IDLE, `res_valid` 0, r2 reads 0 (regfile cleared), and no result is emitted.
